// File: rtl/mf_ce_gen.sv
// mf_ce_gen: fractional clock-enable generator.
// Each channel runs a phase accumulator on the master clock. The accumulator
// wrap gives a one-cycle enable (ce), and the MSB rising edge gives a
// mid-period marker (ce_half). The MSB itself is exported as a square wave.
// A new increment waits in a pending register and is only adopted on a wrap,
// so the period currently running is never cut short or stretched.
module mf_ce_gen #(
  parameter int NUM_CH = 6,
  parameter int ACC_W  = 32,
  parameter logic [NUM_CH*ACC_W-1:0] DEF_INC = {NUM_CH{{3'b001, {(ACC_W-3){1'b0}}}}},
  parameter logic [NUM_CH*ACC_W-1:0] DEF_PHASE = '0,
  parameter int LOCK_CYCLES = 16
) (
  input  logic              refclk,
  input  logic              rst_n,
  input  logic              sync,
  input  logic              cfg_wr,
  input  logic              cfg_sel,
  input  logic [3:0]        cfg_addr,
  input  logic [ACC_W-1:0]  cfg_data,
  output logic [NUM_CH-1:0] ce,
  output logic [NUM_CH-1:0] ce_half,
  output logic [NUM_CH-1:0] clk_out,
  output logic              locked
);

  localparam int CNT_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(LOCK_CYCLES);
  // Largest legal increment: below half the accumulator range, so a single
  // add can never cross both the MSB edge and the wrap at once.
  localparam logic [ACC_W-1:0] INC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [4:0] NUM_CH_5 = 5'(NUM_CH);

  // Clamp an increment to INC_MAX.
  function automatic logic [ACC_W-1:0] clamp_inc(input logic [ACC_W-1:0] d);
    logic [ACC_W-1:0] r;
    if (d[ACC_W-1]) begin
      r = INC_MAX;
    end else begin
      r = d;
    end
    return r;
  endfunction

  logic addr_ok_s;
  logic [CNT_W-1:0] lock_cnt_r;
  logic [CNT_W-1:0] lock_next_s;
  logic locked_r;

  // Decode whether the config address names an existing channel.
  always_comb begin
    addr_ok_s = ({1'b0, cfg_addr} < NUM_CH_5);
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [ACC_W-1:0] acc_r;
    logic [ACC_W-1:0] inc_act_r;
    logic [ACC_W-1:0] inc_pend_r;
    logic [ACC_W-1:0] phase_r;
    logic             ce_r;
    logic             ce_half_r;
    logic             clk_out_r;
    logic [ACC_W:0]   sum_s;
    logic             carry_s;
    logic [ACC_W-1:0] acc_next_s;
    logic             hit_s;
    logic [ACC_W-1:0] pend_new_s;
    logic [ACC_W-1:0] phase_new_s;

    // Accumulate step and the config values after this edge's write.
    always_comb begin
      sum_s       = {1'b0, acc_r} + {1'b0, inc_act_r};
      carry_s     = sum_s[ACC_W];
      acc_next_s  = sum_s[ACC_W-1:0];
      hit_s       = cfg_wr & addr_ok_s & (cfg_addr == 4'(i));
      pend_new_s  = inc_pend_r;
      phase_new_s = phase_r;
      if (hit_s && !cfg_sel) begin
        pend_new_s = clamp_inc(cfg_data);
      end else if (hit_s && cfg_sel) begin
        phase_new_s = cfg_data;
      end else begin
        pend_new_s  = inc_pend_r;
        phase_new_s = phase_r;
      end
    end

    // Channel state: reset defaults, sync realignment, or normal accumulate.
    always_ff @(posedge refclk) begin
      if (!rst_n) begin
        acc_r      <= DEF_PHASE[i*ACC_W +: ACC_W];
        inc_act_r  <= DEF_INC[i*ACC_W +: ACC_W];
        inc_pend_r <= DEF_INC[i*ACC_W +: ACC_W];
        phase_r    <= DEF_PHASE[i*ACC_W +: ACC_W];
        ce_r       <= 1'b0;
        ce_half_r  <= 1'b0;
        clk_out_r  <= 1'b0;
      end else begin
        inc_pend_r <= pend_new_s;
        phase_r    <= phase_new_s;
        if (sync) begin
          acc_r     <= phase_new_s;
          inc_act_r <= pend_new_s;
          ce_r      <= 1'b0;
          ce_half_r <= 1'b0;
          clk_out_r <= phase_new_s[ACC_W-1];
        end else begin
          acc_r     <= acc_next_s;
          ce_r      <= carry_s;
          ce_half_r <= ~acc_r[ACC_W-1] & acc_next_s[ACC_W-1] & ~carry_s;
          clk_out_r <= acc_next_s[ACC_W-1];
          // Adopt the pending rate only at a wrap (or when stopped), using
          // the value held before any write landing on this same edge.
          if (carry_s || (inc_act_r == '0)) begin
            inc_act_r <= inc_pend_r;
          end else begin
            inc_act_r <= inc_act_r;
          end
        end
      end
    end

    assign ce[i]      = ce_r;
    assign ce_half[i] = ce_half_r;
    assign clk_out[i] = clk_out_r;
  end

  // Saturating lock counter step.
  always_comb begin
    if (lock_cnt_r == LOCK_MAX) begin
      lock_next_s = lock_cnt_r;
    end else begin
      lock_next_s = lock_cnt_r + CNT_W'(1);
    end
  end

  // Lock tracking: cleared by reset and sync, set once the count saturates.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      lock_cnt_r <= '0;
      locked_r   <= 1'b0;
    end else if (sync) begin
      lock_cnt_r <= '0;
      locked_r   <= 1'b0;
    end else begin
      lock_cnt_r <= lock_next_s;
      locked_r   <= (lock_next_s == LOCK_MAX);
    end
  end

  assign locked = locked_r;

endmodule

// File: tb/tb_mf_ce_gen.sv
// Testbench for mf_ce_gen: directed scenarios followed by random traffic.
// A behavioural model predicts every cycle's outputs into a queue, and a
// separate monitor process compares them against the DUT.
module tb_mf_ce_gen;
  localparam int NCH  = 6;
  localparam int W    = 32;
  localparam int LOCK = 16;
  localparam longint MOD  = 64'h1_0000_0000;
  localparam longint HALF = 64'h8000_0000;

  logic refclk = 1'b0;
  logic rst_n, sync, cfg_wr, cfg_sel;
  logic [3:0] cfg_addr;
  logic [W-1:0] cfg_data;
  logic [NCH-1:0] ce, ce_half, clk_out;
  logic locked;

  always #5 refclk = ~refclk;

  mf_ce_gen #(.NUM_CH(NCH), .ACC_W(W), .LOCK_CYCLES(LOCK)) dut (
    .refclk(refclk), .rst_n(rst_n), .sync(sync), .cfg_wr(cfg_wr),
    .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .ce(ce), .ce_half(ce_half), .clk_out(clk_out), .locked(locked)
  );

  // Reference model state: values as plain integers.
  longint m_acc[NCH];
  longint m_act[NCH];
  longint m_pend[NCH];
  longint m_ph[NCH];
  int     m_cnt;

  logic [3*NCH:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int n_pushed = 0;
  int n_popped = 0;
  bit stim_done = 1'b0;

  // One master-clock edge of the reference model; returns {locked, clk_out, ce_half, ce}.
  task automatic model_edge(input logic r, input logic s, input logic w, input logic sel,
                            input logic [3:0] a, input logic [W-1:0] d,
                            output logic [3*NCH:0] e);
    longint old_pend[NCH];
    longint dv;
    longint sum;
    logic [NCH-1:0] c, h, k;
    logic l;
    c = '0; h = '0; k = '0; l = 1'b0;
    dv = {32'h0, d};
    if (!r) begin
      for (int ch = 0; ch < NCH; ch++) begin
        m_acc[ch] = 0; m_ph[ch] = 0;
        m_act[ch] = 64'h2000_0000; m_pend[ch] = 64'h2000_0000;
      end
      m_cnt = 0;
    end else begin
      for (int ch = 0; ch < NCH; ch++) old_pend[ch] = m_pend[ch];
      if (w && int'(a) < NCH) begin
        if (sel) m_ph[a] = dv;
        else m_pend[a] = (dv >= HALF) ? HALF - 1 : dv;
      end
      if (s) begin
        for (int ch = 0; ch < NCH; ch++) begin
          m_acc[ch] = m_ph[ch];
          m_act[ch] = m_pend[ch];
          k[ch] = (m_ph[ch] >= HALF);
        end
        m_cnt = 0;
      end else begin
        for (int ch = 0; ch < NCH; ch++) begin
          sum = m_acc[ch] + m_act[ch];
          c[ch] = (sum >= MOD);
          h[ch] = (m_acc[ch] < HALF) && ((sum % MOD) >= HALF) && (sum < MOD);
          k[ch] = ((sum % MOD) >= HALF);
          if (sum >= MOD || m_act[ch] == 0) m_act[ch] = old_pend[ch];
          m_acc[ch] = sum % MOD;
        end
        if (m_cnt < LOCK) m_cnt++;
        l = (m_cnt == LOCK);
      end
    end
    e = {l, k, h, c};
  endtask

  // Drive one cycle of inputs and queue the predicted outputs.
  task automatic step(input logic r, input logic s, input logic w, input logic sel,
                      input logic [3:0] a, input logic [W-1:0] d);
    logic [3*NCH:0] e;
    rst_n = r; sync = s; cfg_wr = w; cfg_sel = sel; cfg_addr = a; cfg_data = d;
    model_edge(r, s, w, sel, a, d, e);
    exp_q.push_back(e);
    n_pushed++;
    @(negedge refclk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
  endtask

  task automatic wr(input logic [3:0] a, input logic sel, input logic [W-1:0] d);
    step(1'b1, 1'b0, 1'b1, sel, a, d);
  endtask

  // Stimulus: directed scenarios, then randomized traffic.
  initial begin : stim
    logic [W-1:0] d;
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
    idle(20);
    wr(4'd1, 1'b1, 32'h8000_0000);
    idle(2);
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0);
    idle(12);
    wr(4'd2, 1'b0, 32'h1999_999A);
    idle(115);
    wr(4'd2, 1'b0, 32'h2000_0000);
    idle(30);
    wr(4'd3, 1'b0, 32'h0);
    idle(10);
    wr(4'd3, 1'b0, 32'h4000_0000);
    idle(20);
    wr(4'd4, 1'b0, 32'hF000_0000);
    idle(1000);
    wr(4'd15, 1'b0, 32'h1234_5678);
    wr(4'd15, 1'b1, 32'h8765_4321);
    idle(5);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
    idle(10);
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 5))
        0: d = 32'h0;
        1: d = 32'h2000_0000;
        2: d = 32'h1999_999A;
        3: d = 32'hF000_0000;
        4: d = 32'h8000_0000;
        default: d = $urandom;
      endcase
      step(($urandom_range(0, 299) != 0), ($urandom_range(0, 59) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
           4'($urandom_range(0, 7)), d);
    end
    stim_done = 1'b1;
  end

  logic [3*NCH:0] mon_exp, mon_act;
  int  since = 0;
  bit  seen_ce0 = 1'b0;
  bit  seen_lock = 1'b0;

  // Monitor: compare DUT outputs against the queued predictions each cycle.
  initial begin : monitor
    forever begin
      @(posedge refclk);
      #1;
      mon_act = {locked, clk_out, ce_half, ce};
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        n_popped++;
        checks++;
        if (mon_act !== mon_exp) begin
          errors++;
          $display("FAIL outputs t=%0t got %h expected %h", $time, mon_act, mon_exp);
        end
        checks++;
        if ((ce & ce_half) != '0) begin
          errors++;
          $display("FAIL ce_overlap t=%0t got %b expected 0", $time, ce & ce_half);
        end
      end
      if (!rst_n) since = 0;
      else since++;
      if (rst_n && !seen_ce0 && ce[0]) begin
        seen_ce0 = 1'b1;
        checks++;
        if (since != 8) begin
          errors++;
          $display("FAIL first_ce0 got edge %0d expected 8", since);
        end
      end
      if (rst_n && !seen_lock && locked) begin
        seen_lock = 1'b1;
        checks++;
        if (since != LOCK) begin
          errors++;
          $display("FAIL first_lock got edge %0d expected %0d", since, LOCK);
        end
      end
      if (stim_done && exp_q.size() == 0) break;
    end
    checks++;
    if (n_popped != n_pushed || !seen_ce0 || !seen_lock) begin
      errors++;
      $display("FAIL drain got %0d/%0d ce0=%0d lock=%0d expected all", n_popped, n_pushed,
               seen_ce0, seen_lock);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Run-time bound in case the clock or processes stall.
  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog timeout got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mf_ce_gen.md
Name: mf_ce_gen

Overview:
- Parametrised fractional clock-enable generator. Runs on the PLL master clock and derives NUM_CH independent clock-enable streams from it.
- Each stream has a runtime-programmable frequency ratio, a phase offset, and half-period markers. This replaces fixed per-rate PLL outputs with single-clock-domain enables.
- Sits between the core PLL and the video/CPU/audio clock consumers (e.g. H32/H40 pixel rates, switchable at runtime).

Parameters:
- NUM_CH, 6, number of enable channels (1..16).
- ACC_W, 32, phase accumulator width per channel (16..48).
- DEF_INC, {NUM_CH{32'h2000_0000}}, packed NUM_CH*ACC_W reset increments, channel 0 in LSBs.
- DEF_PHASE, all zeros, packed NUM_CH*ACC_W reset phase offsets.
- LOCK_CYCLES, 16, master cycles after reset release or sync before locked asserts (>=1).

Ports:
- refclk, input, 1, master clock; all logic on rising edge.
- rst_n, input, 1, synchronous active-low reset.
- sync, input, 1, realign pulse: reload all accumulators with their phase offsets.
- cfg_wr, input, 1, config write strobe.
- cfg_sel, input, 1, 0 = increment register, 1 = phase register.
- cfg_addr, input, 4, channel index; writes to addresses >= NUM_CH are ignored.
- cfg_data, input, ACC_W, write data.
- ce, output, NUM_CH, one-cycle enable pulse per channel at accumulator wrap.
- ce_half, output, NUM_CH, one-cycle pulse when accumulator MSB rises 0->1 (mid-period).
- clk_out, output, NUM_CH, accumulator MSB per channel; ~50% duty square wave for debug/export.
- locked, output, 1, enables stable (alignment settled).

Behaviour:
- Reset (rst_n=0 at edge):
  - acc[i] <= DEF_PHASE[i]; inc_act[i] and inc_pend[i] <= DEF_INC[i]; phase[i] <= DEF_PHASE[i].
  - ce, ce_half, clk_out, locked <= 0; lock counter <= 0.
- Per channel, each edge with rst_n=1 and sync=0:
  - {carry, acc_next} = acc + inc_act, ACC_W-bit modulo add.
  - acc <= acc_next.
  - ce <= carry.
  - ce_half <= (~acc[MSB] & acc_next[MSB] & ~carry).
  - clk_out <= acc_next[MSB].
  - All outputs are registered, so a pulse appears the cycle after the accumulate edge that produced it.
- Increment clamp:
  - inc values >= 2^(ACC_W-1) are clamped to 2^(ACC_W-1)-1 when written.
  - This guarantees at most one ce or one ce_half per cycle, never both.
- inc = 0 stops the channel: acc holds, no pulses, clk_out holds.
- Increment writes (cfg_sel=0):
  - Data goes to inc_pend.
  - inc_pend transfers to inc_act on that channel's next carry edge; the new rate takes effect from the following add. This is glitch-free and keeps the current period intact.
  - If inc_act==0, the transfer happens on the edge after the write.
  - A write and a carry on the same edge: the carry edge transfers the old inc_pend; the new value waits for the next carry.
- Phase writes (cfg_sel=1): update phase immediately. They do not move acc until the next sync or reset.
- Sync (sync=1 at edge, rst_n=1):
  - For all channels: acc <= phase; inc_act <= inc_pend; ce and ce_half <= 0; clk_out <= phase[MSB].
  - Lock counter <= 0; locked <= 0.
  - A cfg write on the same edge is applied first, so the new value is used.
  - Sync held high keeps channels parked at phase.
- Lock counter:
  - Increments each edge while rst_n=1 and sync=0, saturating at LOCK_CYCLES.
  - locked <= 1 on the edge where the counter reaches LOCK_CYCLES.
  - ce streams run regardless of locked.
- Reset mid-operation: discards pending writes and returns to defaults on the same edge.
- Period definition: channel period is 2^ACC_W / inc master cycles on average. Fractional ratios dither between floor and ceil.

Test Plan:
- Reset, then release: ce[0] first high after the 8th edge, then every 8 cycles. ce_half[0] appears 4 cycles after each ce. Square wave: clk_out[0] high for 4 of every 8 cycles. locked rises after the 16th edge.
- Write phase[1] = 32'h8000_0000 with inc 32'h2000_0000, then pulse sync: ce[1] after the 4th edge, ce[0] after the 8th, i.e. a 4-cycle offset. locked drops to 0 at the sync edge.
- Write inc[2] = 32'h1999_999A (divide-by-10): ce[2] period is exactly 10 for the first 10 wraps. Write inc[2] = 32'h2000_0000 mid-period: the current period still completes in 10, the next period is 8.
- Write inc[3] = 0: ce[3], ce_half[3], clk_out[3] freeze. Then write 32'h4000_0000: ce[3] resumes with period 4 from the edge after the write.
- Write inc = 32'hF000_0000 to channel 4: stored value is 32'h7FFF_FFFF. Over 1000 cycles ce and ce_half are never high together.
- Write to cfg_addr=15 with NUM_CH=6: no channel changes. Assert rst_n=0 mid-stream: all outputs are 0 the following cycle and defaults are restored.
